// File: rtl/img_receive_uart.sv
// 8N1 UART receiver that streams image bytes into consecutive BRAM addresses
// starting at 0, and raises a sticky done flag once the whole image is stored.
module img_receive_uart #(
   parameter int CLKS_PER_BIT = 10416,
   parameter int NUM_PIXELS   = 22500,
   parameter int ADDR_W       = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RxD,
   output logic              ena_rx,
   output logic              wea_rx,
   output logic [ADDR_W-1:0] addr_rx,
   output logic [7:0]        din_rx,
   output logic              rx_done,
   output logic              frame_err,
   output logic [ADDR_W:0]   byte_count
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   BC_ONE   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   BC_LAST  = (ADDR_W+1)'(NUM_PIXELS);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_WRITE = 3'd4
   } state_t;

   state_t             r_state;
   logic               r_rx_meta;
   logic               r_rxs;
   logic               r_armed;
   logic [CNT_W-1:0]   r_cnt;
   logic [2:0]         r_idx;
   logic [7:0]         r_shift;
   logic [ADDR_W:0]    w_count_next;

   assign ena_rx       = 1'b1;
   assign w_count_next = byte_count + BC_ONE;

   // Two-flop synchronizer for the asynchronous serial line (idle high).
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_meta <= 1'b1;
         r_rxs     <= 1'b1;
      end else begin
         r_rx_meta <= RxD;
         r_rxs     <= r_rx_meta;
      end
   end

   // Receive FSM with registered BRAM port, status flags and byte counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_armed    <= 1'b0;
         r_cnt      <= '0;
         r_idx      <= 3'd0;
         r_shift    <= 8'h00;
         wea_rx     <= 1'b0;
         addr_rx    <= '0;
         din_rx     <= 8'h00;
         rx_done    <= 1'b0;
         frame_err  <= 1'b0;
         byte_count <= '0;
      end else begin
         wea_rx    <= 1'b0;
         frame_err <= 1'b0;

         // The cycle after a write pulse commits it: count, then advance or finish.
         if (wea_rx) begin
            byte_count <= w_count_next;
            if (w_count_next == BC_LAST) begin
               rx_done <= 1'b1;
            end else begin
               addr_rx <= addr_rx + ADDR_ONE;
            end
         end else begin
            byte_count <= byte_count;
         end

         case (r_state)
            S_IDLE: begin
               if (r_rxs) begin
                  r_armed <= 1'b1;
               end else if (r_armed) begin
                  r_cnt   <= '0;
                  r_state <= S_START;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_START: begin
               if (r_cnt == HALF_CNT) begin
                  if (!r_rxs) begin
                     r_cnt   <= '0;
                     r_idx   <= 3'd0;
                     r_state <= S_DATA;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            S_DATA: begin
               if (r_cnt == FULL_CNT) begin
                  r_shift[r_idx] <= r_rxs;
                  r_cnt          <= '0;
                  if (r_idx == 3'd7) begin
                     r_state <= S_STOP;
                  end else begin
                     r_idx <= r_idx + 3'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            S_STOP: begin
               if (r_cnt == FULL_CNT) begin
                  if (r_rxs) begin
                     r_state <= S_WRITE;
                  end else begin
                     // Clearing armed keeps a held-low break from looking like a start bit.
                     frame_err <= 1'b1;
                     r_armed   <= 1'b0;
                     r_state   <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            S_WRITE: begin
               if (!rx_done) begin
                  wea_rx <= 1'b1;
                  din_rx <= r_shift;
               end else begin
                  wea_rx <= 1'b0;
               end
               r_armed <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_img_receive_uart.sv
// Scoreboard bench for img_receive_uart: stimulus pushes expected writes,
// a negedge monitor pops and compares every BRAM write pulse.
`timescale 1ns/1ps
module tb_img_receive_uart;

   localparam int CPB    = 16;
   localparam int NPIX   = 4;
   localparam int AW     = 4;
   localparam real BIT_NS = 160.0;

   logic          clk;
   logic          reset;
   logic          RxD;
   logic          ena_rx;
   logic          wea_rx;
   logic [AW-1:0] addr_rx;
   logic [7:0]    din_rx;
   logic          rx_done;
   logic          frame_err;
   logic [AW:0]   byte_count;

   int errors = 0;
   int checks = 0;
   int fe_seen = 0;
   bit done_chk = 1'b0;
   logic [15:0] sb_q[$];

   img_receive_uart #(.CLKS_PER_BIT(CPB), .NUM_PIXELS(NPIX), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .RxD(RxD), .ena_rx(ena_rx), .wea_rx(wea_rx),
      .addr_rx(addr_rx), .din_rx(din_rx), .rx_done(rx_done),
      .frame_err(frame_err), .byte_count(byte_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_wr(input logic [7:0] a, input logic [7:0] d);
      sb_q.push_back({a, d});
   endtask

   task automatic send_byte(input logic [7:0] b, input real bit_ns, input logic stop);
      RxD = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         RxD = b[i];
         #(bit_ns);
      end
      RxD = stop;
      #(bit_ns);
      RxD = 1'b1;
   endtask

   task automatic do_reset();
      RxD   = 1'b1;
      reset = 1'b1;
      repeat (4) @(posedge clk);
      reset = 1'b0;
      fe_seen = 0;
      repeat (4) @(posedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   // Monitor: every write pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (reset) begin
         done_chk = 1'b0;
      end else begin
         if (done_chk) begin
            chk("rx_done_rise", {31'd0, rx_done}, 32'd1);
            done_chk = 1'b0;
         end
         if (wea_rx) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr=%0d din=%02h, expected no write", addr_rx, din_rx);
            end else begin
               logic [15:0] e;
               e = sb_q.pop_front();
               chk("wr_addr", {28'd0, addr_rx}, {24'd0, e[15:8]});
               chk("wr_data", {24'd0, din_rx}, {24'd0, e[7:0]});
               chk("done_before_write", {31'd0, rx_done}, 32'd0);
               if (e[15:8] == 8'(NPIX - 1)) done_chk = 1'b1;
            end
         end
         if (frame_err) fe_seen++;
      end
   end

   initial begin
      logic [7:0] pb;
      RxD   = 1'b1;
      reset = 1'b1;
      repeat (4) @(posedge clk);
      reset = 1'b0;

      // Idle line after reset: reset values, no writes.
      idle(100);
      chk("rst_wea", {31'd0, wea_rx}, 32'd0);
      chk("rst_addr", {28'd0, addr_rx}, 32'd0);
      chk("rst_din", {24'd0, din_rx}, 32'd0);
      chk("rst_done", {31'd0, rx_done}, 32'd0);
      chk("rst_ferr", {31'd0, frame_err}, 32'd0);
      chk("rst_count", {27'd0, byte_count}, 32'd0);
      chk("ena", {31'd0, ena_rx}, 32'd1);

      // Single ideal byte.
      expect_wr(8'd0, 8'hA5);
      send_byte(8'hA5, BIT_NS, 1'b1);
      idle(10);
      chk("a5_addr", {28'd0, addr_rx}, 32'd1);
      chk("a5_count", {27'd0, byte_count}, 32'd1);
      chk("a5_pending", sb_q.size(), 32'd0);

      // Back-to-back fill, then one extra byte after done.
      do_reset();
      expect_wr(8'd0, 8'h00);
      expect_wr(8'd1, 8'hFF);
      expect_wr(8'd2, 8'h3C);
      expect_wr(8'd3, 8'h81);
      send_byte(8'h00, BIT_NS, 1'b1);
      send_byte(8'hFF, BIT_NS, 1'b1);
      send_byte(8'h3C, BIT_NS, 1'b1);
      send_byte(8'h81, BIT_NS, 1'b1);
      send_byte(8'h55, BIT_NS, 1'b1);
      idle(20);
      chk("full_addr", {28'd0, addr_rx}, 32'd3);
      chk("full_count", {27'd0, byte_count}, 32'd4);
      chk("full_done", {31'd0, rx_done}, 32'd1);
      chk("full_pending", sb_q.size(), 32'd0);

      // Short low glitch is ignored.
      do_reset();
      RxD = 1'b0;
      #30;
      RxD = 1'b1;
      idle(60);
      chk("glitch_ferr", fe_seen, 32'd0);
      chk("glitch_count", {27'd0, byte_count}, 32'd0);

      // Framing error, held-low break, then a valid byte.
      do_reset();
      expect_wr(8'd0, 8'h12);
      send_byte(8'h7E, BIT_NS, 1'b0);
      RxD = 1'b0;
      repeat (40) @(posedge clk);
      RxD = 1'b1;
      repeat (2 * CPB) @(posedge clk);
      chk("break_ferr", fe_seen, 32'd1);
      chk("break_count", {27'd0, byte_count}, 32'd0);
      send_byte(8'h12, BIT_NS, 1'b1);
      idle(10);
      chk("fe_total", fe_seen, 32'd1);
      chk("fe_count", {27'd0, byte_count}, 32'd1);
      chk("fe_pending", sb_q.size(), 32'd0);

      // Reset in the middle of bit 4 aborts the frame.
      pb = 8'h5A;
      RxD = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 4; i++) begin
         RxD = pb[i];
         #(BIT_NS);
      end
      RxD = pb[4];
      #(BIT_NS / 2.0);
      do_reset();
      idle(2 * CPB);
      chk("abort_count", {27'd0, byte_count}, 32'd0);
      chk("abort_addr", {28'd0, addr_rx}, 32'd0);
      expect_wr(8'd0, 8'h99);
      expect_wr(8'd1, 8'hC3);
      expect_wr(8'd2, 8'hC3);
      send_byte(8'h99, BIT_NS, 1'b1);
      send_byte(8'hC3, BIT_NS * 1.02, 1'b1);
      send_byte(8'hC3, BIT_NS * 0.98, 1'b1);
      idle(10);
      chk("baud_count", {27'd0, byte_count}, 32'd3);
      chk("baud_addr", {28'd0, addr_rx}, 32'd3);
      chk("baud_ferr", fe_seen, 32'd0);
      chk("baud_pending", sb_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/img_receive_uart.md
Name: img_receive_uart

Overview:
- UART receiver (8N1, LSB first) that loads an image streamed from the host PC into the shared image block RAM, one byte per pixel, at consecutive addresses from 0.
- Sits on the load side of the image-processing pipeline.
- Mirrors the image transmit path: same baud divisor, same byte framing, same BRAM port style (enable, write-enable, address, write-data).
- Raises a sticky done flag once the full image is stored, so the processing stage can start.

Parameters:
- CLKS_PER_BIT, 10416, clk cycles per UART bit (100 MHz / 9600 baud); must be at least 4.
- NUM_PIXELS, 22500, bytes per image (150x150); last address written is NUM_PIXELS-1.
- ADDR_W, 15, BRAM address width; 2^ADDR_W must be at least NUM_PIXELS.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- RxD  in  1  asynchronous serial input; idle high.
- ena_rx  out  1  BRAM port enable; constant 1.
- wea_rx  out  1  BRAM write enable; one-cycle pulse per stored byte.
- addr_rx  out  ADDR_W  BRAM write address.
- din_rx  out  8  BRAM write data (received byte).
- rx_done  out  1  sticky; high once NUM_PIXELS bytes are stored.
- frame_err  out  1  one-cycle pulse when a stop bit samples 0.
- byte_count  out  ADDR_W+1  number of bytes stored so far (0..NUM_PIXELS).

Behaviour:
- Reset state: wea_rx=0, addr_rx=0, din_rx=0, rx_done=0, frame_err=0, byte_count=0.
- Reset also clears the state (IDLE), the baud counter, the bit index, the shift register, and the armed flag.
- Reset mid-frame aborts the frame with no write.
- Input synchronizer: RxD passes through a 2-flop synchronizer; all logic uses the synchronized value rxs (2-cycle latency).
- Baud counter: a single counter, width ceil(log2(CLKS_PER_BIT)).
- IDLE:
  - armed is set when rxs=1.
  - When rxs=0 and armed=1: clear the counter, enter START.
  - While armed=0 (line held low, e.g. a break after a framing error), stay in IDLE.
- START:
  - When the counter reaches CLKS_PER_BIT/2-1 (mid start bit), re-sample rxs.
  - rxs=0: clear the counter and bit index, enter DATA.
  - rxs=1: treat as a glitch and return to IDLE; no error reported.
- DATA:
  - When the counter reaches CLKS_PER_BIT-1, sample rxs into shift-register bit [index], LSB first, then clear the counter.
  - After index 7 is sampled, enter STOP.
- STOP: when the counter reaches CLKS_PER_BIT-1, sample rxs.
  - rxs=1: enter WRITE.
  - rxs=0: pulse frame_err for 1 cycle, discard the byte, clear armed, enter IDLE.
- WRITE (exactly 1 cycle):
  - If rx_done=0: wea_rx=1, din_rx=byte, addr_rx=current address.
  - On the next cycle: if byte_count+1 == NUM_PIXELS, set rx_done=1 and hold addr_rx at NUM_PIXELS-1; otherwise addr_rx increments. byte_count increments in both cases.
  - If rx_done=1: no write, no increment; the byte is dropped silently.
  - Always returns to IDLE, with armed=1 (the stop bit was high).
- Frame timing: a frame is about 9.5 bit times from the start edge to the write. Back-to-back frames with no idle time between them are received without loss, because IDLE is entered mid stop bit.
- Address never wraps; addresses at or above NUM_PIXELS are never written.
- A simultaneous new start edge during WRITE is caught on the following IDLE cycle; the edge is at most 1 cycle late, which is within tolerance.
- Sampling points sit within ±1 cycle of bit centres for a matched baud rate. The design tolerates ±2% baud mismatch.

Test Plan (benches use CLKS_PER_BIT=16, NUM_PIXELS=4 for speed; one run at the defaults):
- Reset, then RxD=1 for 100 cycles -> no wea_rx pulse; all outputs at reset values; ena_rx=1.
- Send byte 0xA5 with ideal timing -> exactly one wea_rx pulse with addr_rx=0 and din_rx=0xA5; afterwards addr_rx=1 and byte_count=1.
- Send 0x00, 0xFF, 0x3C, 0x81 back-to-back with no idle gap -> writes at addresses 0..3 with those values; rx_done rises on the cycle after the 4th write. A 5th byte 0x55 produces no write; addr_rx stays 3, byte_count stays 4.
- Low glitch on RxD of 3 cycles -> returns to IDLE; no frame_err, no write.
- Frame 0x7E with stop bit forced 0, line held low 40 cycles, then high, then a valid 0x12 -> one frame_err pulse; no write for 0x7E; no false start during the low period; 0x12 written at address 0.
- Assert reset during bit 4 of a frame, release, then send 0x99 -> no partial write; 0x99 written at address 0. Also send 0xC3 at ±2% baud -> received correctly.
